// File: rtl/branch_history_predictor.sv
// Dynamic branch predictor: 2-bit saturating counter table indexed by PC,
// combinational IF prediction, ID misprediction detection, training and stats.
module branch_history_predictor #(
  parameter int INDEX_BITS = 4,
  parameter int PC_WIDTH   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] lookupPC,
  input  logic [5:0]          lookupOpCode,
  output logic                predictTaken,
  output logic                predictJump,
  input  logic                stall,
  input  logic                resValid,
  input  logic [PC_WIDTH-1:0] resPC,
  input  logic [5:0]          resOpCode,
  input  logic                compResult,
  input  logic                resPredTaken,
  output logic                mispredict,
  output logic                redirectTaken,
  output logic [15:0]         branchCount,
  output logic [15:0]         missCount
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [5:0] OP_JUMP = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;

  logic [1:0]            counterTable [ENTRIES];
  logic [INDEX_BITS-1:0] lookupIdx;
  logic [INDEX_BITS-1:0] resIdx;
  logic                  lookupIsBranch;
  logic                  resIsBranch;
  logic                  actualTaken;
  logic                  resolve;

  // Only the word-aligned index bits of either PC select a table entry.
  logic unusedPcBits;
  assign unusedPcBits = ^{lookupPC[PC_WIDTH-1:INDEX_BITS+2], lookupPC[1:0],
                          resPC[PC_WIDTH-1:INDEX_BITS+2], resPC[1:0]};

  assign lookupIdx      = lookupPC[INDEX_BITS+1:2];
  assign resIdx         = resPC[INDEX_BITS+1:2];
  assign lookupIsBranch = (lookupOpCode == OP_BEQ) || (lookupOpCode == OP_BNE);
  assign resIsBranch    = (resOpCode == OP_BEQ) || (resOpCode == OP_BNE);

  assign predictTaken = lookupIsBranch & counterTable[lookupIdx][1];
  assign predictJump  = (lookupOpCode == OP_JUMP);

  assign actualTaken   = ((resOpCode == OP_BEQ) & compResult) |
                         ((resOpCode == OP_BNE) & ~compResult);
  assign resolve       = resValid & ~stall & resIsBranch;
  assign mispredict    = resolve & (actualTaken != resPredTaken);
  assign redirectTaken = actualTaken;

  // Lookup reads the pre-edge table, so a same-index update is seen next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        counterTable[i] <= 2'b01;
      end
      branchCount <= '0;
      missCount   <= '0;
    end else if (resolve) begin
      if (actualTaken && (counterTable[resIdx] != 2'b11)) begin
        counterTable[resIdx] <= counterTable[resIdx] + 2'd1;
      end else if (!actualTaken && (counterTable[resIdx] != 2'b00)) begin
        counterTable[resIdx] <= counterTable[resIdx] - 2'd1;
      end
      if (branchCount != 16'hFFFF) begin
        branchCount <= branchCount + 16'd1;
      end
      if (mispredict && (missCount != 16'hFFFF)) begin
        missCount <= missCount + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_history_predictor.sv
// Bench for branch_history_predictor: directed scenarios plus random traffic
// compared against an array-based predictor model.
module tb_branch_history_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookupPC;
  logic [5:0]  lookupOpCode;
  logic        predictTaken;
  logic        predictJump;
  logic        stall;
  logic        resValid;
  logic [31:0] resPC;
  logic [5:0]  resOpCode;
  logic        compResult;
  logic        resPredTaken;
  logic        mispredict;
  logic        redirectTaken;
  logic [15:0] branchCount;
  logic [15:0] missCount;

  branch_history_predictor #(.INDEX_BITS(4), .PC_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .lookupPC(lookupPC), .lookupOpCode(lookupOpCode),
    .predictTaken(predictTaken), .predictJump(predictJump),
    .stall(stall), .resValid(resValid), .resPC(resPC), .resOpCode(resOpCode),
    .compResult(compResult), .resPredTaken(resPredTaken),
    .mispredict(mispredict), .redirectTaken(redirectTaken),
    .branchCount(branchCount), .missCount(missCount)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int failCount  = 0;

  int refTable [16];
  int refBranches;
  int refMisses;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 16; i++) refTable[i] = 1;
    refBranches = 0;
    refMisses   = 0;
  endtask

  // One pipeline cycle: drive after the falling edge, check, then update model at the rising edge.
  task automatic doCycle(input bit r, input logic [31:0] lpc, input logic [5:0] lop,
                         input bit st, input bit rv, input logic [31:0] rpc,
                         input logic [5:0] rop, input bit cr, input bit rpt);
    bit lIsBr, rIsBr, actual, res, expMiss, expPred;
    int li, ri;
    rst = r; lookupPC = lpc; lookupOpCode = lop; stall = st; resValid = rv;
    resPC = rpc; resOpCode = rop; compResult = cr; resPredTaken = rpt;
    #1;
    lIsBr  = (lop == 6'd4) || (lop == 6'd5);
    rIsBr  = (rop == 6'd4) || (rop == 6'd5);
    li     = int'(lpc[5:2]);
    ri     = int'(rpc[5:2]);
    actual = (rop == 6'd4) ? cr : (rop == 6'd5) ? !cr : 1'b0;
    res    = rv && !st && rIsBr;
    expMiss = res && (actual != rpt);
    expPred = lIsBr && (refTable[li] >= 2);
    checkVal("predictTaken", 32'(predictTaken), 32'(expPred));
    checkVal("predictJump", 32'(predictJump), 32'(lop == 6'd2));
    checkVal("mispredict", 32'(mispredict), 32'(expMiss));
    if (expMiss) checkVal("redirectTaken", 32'(redirectTaken), 32'(actual));
    checkVal("branchCount", 32'(branchCount), 32'(refBranches));
    checkVal("missCount", 32'(missCount), 32'(refMisses));
    @(posedge clk);
    if (r) begin
      resetModel();
    end else if (res) begin
      refTable[ri] = actual ? ((refTable[ri] == 3) ? 3 : refTable[ri] + 1)
                            : ((refTable[ri] == 0) ? 0 : refTable[ri] - 1);
      if (refBranches < 65535) refBranches++;
      if (expMiss && refMisses < 65535) refMisses++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    doCycle(0, 32'h0, 6'd0, 0, 0, 32'h0, 6'd0, 0, 0);
  endtask

  // Sweep every entry through the lookup port so the table contents are compared.
  task automatic sweepTable();
    for (int i = 0; i < 16; i++) doCycle(0, 32'(i * 4), 6'd4, 0, 0, 32'h0, 6'd0, 0, 0);
  endtask

  initial begin
    logic [5:0] ops [5];
    ops[0] = 6'd0; ops[1] = 6'd2; ops[2] = 6'd4; ops[3] = 6'd5; ops[4] = 6'd35;

    rst = 1; lookupPC = 0; lookupOpCode = 0; stall = 0; resValid = 0;
    resPC = 0; resOpCode = 0; compResult = 0; resPredTaken = 0;
    @(negedge clk); @(negedge clk);
    resetModel();
    rst = 0;

    // Post-reset: weak-NT everywhere, jump prediction.
    sweepTable();
    doCycle(0, 32'h100, 6'd2, 0, 0, 32'h0, 6'd0, 0, 0);

    // beq at 0x40 taken twice.
    doCycle(0, 32'h40, 6'd4, 0, 1, 32'h40, 6'd4, 1, 0);
    doCycle(0, 32'h40, 6'd4, 0, 1, 32'h40, 6'd4, 1, 1);
    doCycle(0, 32'h40, 6'd4, 0, 0, 32'h0, 6'd0, 0, 0);
    checkVal("dirBranchCount", 32'(branchCount), 32'd2);
    checkVal("dirMissCount", 32'(missCount), 32'd1);

    // bne at 0x08 not taken three times saturates entry 2 at strong-NT.
    for (int k = 0; k < 3; k++) doCycle(0, 32'h08, 6'd5, 0, 1, 32'h08, 6'd5, 1, 0);
    doCycle(0, 32'h08, 6'd5, 0, 0, 32'h0, 6'd0, 0, 0);

    // Collision on entry 5: lookup sees the pre-update value.
    doCycle(0, 32'h14, 6'd4, 0, 1, 32'h54, 6'd4, 1, 0);
    doCycle(0, 32'h14, 6'd4, 0, 0, 32'h0, 6'd0, 0, 0);

    // Stall holds the resolve off for two cycles.
    doCycle(0, 32'h0, 6'd0, 1, 1, 32'h30, 6'd4, 1, 0);
    doCycle(0, 32'h0, 6'd0, 1, 1, 32'h30, 6'd4, 1, 0);
    doCycle(0, 32'h0, 6'd0, 0, 1, 32'h30, 6'd4, 1, 0);

    // Jumps in ID never resolve.
    doCycle(0, 32'h0, 6'd0, 0, 1, 32'h30, 6'd2, 1, 1);
    sweepTable();

    // Randomized traffic with occasional stalls and resets.
    for (int n = 0; n < 3000; n++) begin
      doCycle(($urandom_range(0, 199) == 0),
              $urandom, ops[$urandom_range(0, 4)],
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0),
              $urandom, ops[$urandom_range(0, 4)],
              1'($urandom), 1'($urandom));
    end
    sweepTable();

    // Count saturation: every resolve mispredicts, drive past 16'hFFFF.
    doCycle(1, 32'h0, 6'd0, 0, 0, 32'h0, 6'd0, 0, 0);
    for (int n = 0; n < 65534 + 3; n++) begin
      doCycle(0, 32'h0, 6'd0, 0, 1, 32'h60, 6'd4, 1, 0);
    end
    idle();
    checkVal("satBranchCount", 32'(branchCount), 32'hFFFF);
    checkVal("satMissCount", 32'(missCount), 32'hFFFF);

    // Reset wins over a simultaneous resolve.
    doCycle(1, 32'h0, 6'd0, 0, 1, 32'h60, 6'd4, 0, 1);
    idle();
    checkVal("rstBranchCount", 32'(branchCount), 32'd0);
    checkVal("rstMissCount", 32'(missCount), 32'd0);
    sweepTable();

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
